// File: rtl/rv_fetch_pkg.sv
// Shared constants and entry layouts for the instruction fetch queue.
package rv_fetch_pkg;

  localparam int          FQ_DEPTH     = 4;
  localparam int          MAX_OUTST    = 2;
  localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // One decoded-side buffer slot: fetch address plus the instruction word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // One in-flight request: the epoch it was issued under and its address.
  typedef struct packed {
    logic        epoch;
    logic [31:0] pc;
  } trk_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a registered storage array, a clear input
// and an occupancy count. The head entry is always visible on pop_data.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop   = pop && (count != '0);
  assign do_push  = push && ((count < CW'(DEPTH)) || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointer and count bookkeeping; clear and reset both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        if (wr_ptr == PW'(DEPTH - 1)) wr_ptr <= '0;
        else                          wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        if (rd_ptr == PW'(DEPTH - 1)) rd_ptr <= '0;
        else                          rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues imem requests from the PC stage, tracks
// them in order with the epoch they were issued under, and buffers the
// returning instructions for decode. A flush bumps the epoch so responses
// to requests issued before the redirect are silently dropped.
module fetch_queue #(
  parameter int FQ_DEPTH  = rv_fetch_pkg::FQ_DEPTH,
  parameter int MAX_OUTST = rv_fetch_pkg::MAX_OUTST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_accept,
  output logic        fq_stall,
  input  logic        flush,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  import rv_fetch_pkg::*;

  localparam int IBW = $clog2(FQ_DEPTH) + 1;
  localparam int TKW = $clog2(MAX_OUTST) + 1;

  logic [IBW-1:0] ib_count;
  logic [TKW-1:0] outst;
  logic [7:0]     occupancy;
  logic           epoch;
  fq_entry_t      ib_in;
  fq_entry_t      ib_head;
  trk_entry_t     trk_in;
  trk_entry_t     trk_head;
  logic           resp_fire;
  logic           resp_keep;
  logic           deq;

  // Every in-flight request already owns a buffer slot, so the response
  // can always be enqueued without backpressure.
  assign occupancy      = 8'(ib_count) + 8'(outst);
  assign imem_req_valid = !rst && !flush && (occupancy < 8'(FQ_DEPTH))
                          && (outst < TKW'(MAX_OUTST));
  assign imem_req_addr  = pc_in;
  assign pc_accept      = imem_req_valid && imem_req_ready;
  assign fq_stall       = !pc_accept && !flush;

  assign resp_fire = imem_resp_valid && (outst != '0);
  assign resp_keep = resp_fire && (trk_head.epoch == epoch) && !flush;

  assign id_valid = (ib_count != '0);
  assign deq      = id_valid && id_ready;
  assign id_instr = id_valid ? ib_head.instr : NOP_INSTR;
  assign id_pc    = id_valid ? ib_head.pc    : 32'h0;

  assign trk_in = '{epoch: epoch, pc: pc_in};
  assign ib_in  = '{pc: trk_head.pc, instr: imem_resp_data};

  // Epoch flips on each redirect so in-flight requests become stale.
  always_ff @(posedge clk) begin
    if (rst)        epoch <= 1'b0;
    else if (flush) epoch <= ~epoch;
  end

  sync_fifo #(
    .WIDTH ($bits(trk_entry_t)),
    .DEPTH (MAX_OUTST)
  ) u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (pc_accept),
    .push_data (trk_in),
    .pop       (resp_fire),
    .pop_data  (trk_head),
    .count     (outst)
  );

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (resp_keep),
    .push_data (ib_in),
    .pop       (deq),
    .pop_data  (ib_head),
    .count     (ib_count)
  );

endmodule
